// File: rtl/mem_arb_pkg.sv
// Types shared by the instruction/data memory arbiter.
// This package is kept apart from the core-wide type package.
package mem_arb_pkg;

  localparam int unsigned WordW = 32;

  typedef logic [WordW-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Loadable down-counter with a clear/expire interface.
// While load is high it re-arms; while enabled it counts down and flags expiry at zero.
module arb_watchdog #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= load_val;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// Data has priority; a starvation counter forces a pending fetch through, and a watchdog aborts hung accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_W     = WordW,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  output logic              ierr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              derr,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [WORD_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic              ram_rdy,
  input  logic              ram_err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          d_req, i_force, wd_expire, fail, fin;

  // Watchdog is armed with TIMEOUT-1 in IDLE and expires on the TIMEOUT-th access cycle.
  arb_watchdog #(
    .W (WW)
  ) u_watchdog (
    .clk      (CLK),
    .rst      (RST),
    .load     (state_q == IDLE),
    .load_val (WW'(TIMEOUT - 1)),
    .en       (state_q != IDLE),
    .expire   (wd_expire)
  );

  always_comb begin
    d_req     = dREN | dWEN;
    i_force   = iREN && (starve_q == SW'(STARVE_MAX));
    fail      = ram_err || (wd_expire && !ram_rdy);
    fin       = (ram_rdy || fail) && !RST;
    state_d   = state_q;
    starve_d  = starve_q;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    ierr      = 1'b0;
    derr      = 1'b0;
    iload     = '0;
    dload     = '0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !i_force) begin
          state_d = DACC;
          if (iREN && (starve_q != SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);
        end else if (iREN) begin
          state_d  = IACC;
          starve_d = '0;
        end
      end
      IACC: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ram_ren  = 1'b1;
          ram_addr = iaddr;
          if (fin) begin
            iwait   = 1'b0;
            ierr    = fail;
            iload   = fail ? '0 : ram_load;
            state_d = IDLE;
          end
        end
      end
      DACC: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ram_addr  = daddr;
          ram_wen   = dWEN;
          ram_ren   = !dWEN;
          ram_store = dWEN ? dstore : '0;
          if (fin) begin
            dwait   = 1'b0;
            derr    = fail;
            dload   = (fail || dWEN) ? '0 : ram_load;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A fetch that is no longer pending carries no starvation history.
    if (!iREN) starve_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the instruction-fetch requester and the data (load/store) requester of one core; drives one shared RAM port.
- Sits between the datapath/request-unit handshake (REN/WEN/wait) and the RAM controller.
- Data requests have priority. A starvation counter guarantees forward progress for instruction fetch.
- A watchdog converts a hung RAM access into an error response.

Parameters:
WORD_W, 32, data and address width in bits
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced through
TIMEOUT, 255, cycles in an access state without ram_rdy before the access is aborted with error

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
iREN  in  1  instruction read request; held until iwait low
iaddr  in  WORD_W  instruction address
iwait  out  1  low for exactly the completing cycle of the instruction access
iload  out  WORD_W  instruction read data; valid when iwait low
ierr  out  1  pulses with iwait low when the fetch aborted (timeout or ram_err)
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  WORD_W  data address
dstore  in  WORD_W  write data
dwait  out  1  low for exactly the completing cycle of the data access
dload  out  WORD_W  data read data; valid when dwait low
derr  out  1  pulses with dwait low on abort
ram_ren  out  1  RAM read enable
ram_wen  out  1  RAM write enable
ram_addr  out  WORD_W  RAM address
ram_store  out  WORD_W  RAM write data
ram_load  in  WORD_W  RAM read data
ram_rdy  in  1  RAM completes the current access this cycle
ram_err  in  1  RAM reports a fault this cycle

Behaviour:
- Clock and reset: CLK is the only clock. RST is synchronous and active-high. While RST is high at an edge: state goes to IDLE, starve_cnt=0, wd_cnt=0.
- Outputs during reset: iwait=1, dwait=1, ierr=0, derr=0, ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0, iload=0, dload=0.
- RST asserted mid-access: access is dropped with no completion pulse. RAM enables drop the cycle after the reset edge.
- FSM states: IDLE, IACC, DACC.
- IDLE: RAM enables low; both waits high. At the edge:
  - go to DACC if (dREN|dWEN) and !(iREN && starve_cnt==STARVE_MAX);
  - else go to IACC if iREN;
  - else stay in IDLE.
- IACC: ram_ren=1, ram_addr=iaddr.
- DACC: ram_addr=daddr.
  - dWEN=1: ram_wen=1, ram_store=dstore, ram_ren=0. dWEN has precedence if both dREN and dWEN are high.
  - read: ram_ren=1, ram_store=0.
- Completion: in XACC, ram_rdy=1 → Xwait=0 combinationally that cycle. Xload=ram_load for reads, 0 for writes. Next state is IDLE.
- Latency: one arbitration bubble per access. Total request-to-completion = 1 + RAM latency cycles. A RAM answering in the first access cycle gives a 2-cycle access, and back-to-back accesses then complete every 2 cycles.
- Error: ram_err in XACC → Xwait=0, Xerr=1, Xload=0, go to IDLE. ram_err has precedence over ram_rdy.
- Watchdog: wd_cnt increments every cycle in IACC/DACC and clears in IDLE. When wd_cnt==TIMEOUT-1 without ram_rdy/ram_err, the access completes with Xerr=1 and the FSM goes to IDLE.
- Request withdrawn mid-access (granted REN/WEN low while in XACC): go to IDLE next edge with no completion pulse; RAM enables drop combinationally that cycle.
- Xwait of the non-granted requester is always 1.
- Starvation counter (width $clog2(STARVE_MAX+1)):
  - +1 on each DACC entry taken while iREN=1, saturating at STARVE_MAX;
  - cleared on IACC entry, or in any cycle iREN=0.
- Requesters must hold address and data stable while Xwait=1. The arbiter does not latch them.

Decomposition:
- Package mem_arb_pkg: typedef enum logic [1:0] arb_state_t {IDLE, IACC, DACC}, and word_t = logic [WORD_W-1:0].
- Keep this package separate from the core type package.
- Optional sub-module arb_watchdog: loadable down-counter with clear/expire, reusable by other controllers. The main FSM stays in mem_arbiter.

Test Plan:
- Reset: RST high 3 cycles with iREN=dREN=1 → iwait=dwait=1, ram_ren=ram_wen=0, ram_addr=0. First grant goes to DACC at the edge after RST falls.
- Single fetch: iREN=1, iaddr=0x40, RAM ready in 2nd access cycle with ram_load=0x2402000A → iwait low only at cycle 3 after the request, iload=0x2402000A, ram_addr=0x40 during IACC.
- Contention and starvation: iREN held with 6 back-to-back dWEN stores, STARVE_MAX=4 → grant order D,D,D,D,I,D,D. dstore values appear on ram_store only in DACC.
- Store/load ordering: dWEN to 0x100 data 0xDEADBEEF, then dREN 0x100 → ram_wen then ram_ren to the same address. dload=0xDEADBEEF from the RAM model. ram_ren/ram_wen never both high.
- Faults: ram_err during DACC → dwait=0, derr=1 for 1 cycle, dload=0. With TIMEOUT=8 and ram_rdy never high in IACC → iwait=0, ierr=1 exactly on the 8th access cycle.
- Abort and mid-reset: drop dREN during DACC → no dwait pulse, IDLE next edge. Assert RST during IACC → no ierr pulse, and all outputs match reset values after the edge.
